// File: rtl/icache_pkg.sv
// Shared geometry, refill FSM state encoding and line-address helper for the icache refill path.
// A line is four 32-bit beats (128 bits), always 16-byte aligned.
package icache_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int BEATS  = 4;
    localparam int LINE_W = WORD_W * BEATS;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} state_t;
    typedef logic [1:0] beat_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_W / 8 - 1);
    endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Beat request bus to instruction memory: request/address held until mem_ready returns data.
// master = refill controller, slave = memory.
interface icache_refill_ctrl_if;
    import icache_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/icache_refill_ctrl_line_buf.sv
// refill_line_buf: four 32-bit lanes written one beat at a time; flat line visible one cycle after write.
// No backpressure; clr (flush) wins over a same-cycle write so partial lines never survive.
module refill_line_buf
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              we,
    input  beat_t             idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] line
);

    logic [BEATS-1:0][WORD_W-1:0] lane_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q <= '0;
        end else if (clr) begin
            lane_q <= '0;
        end else if (we) begin
            lane_q[idx] <= wdata;
        end
    end

    assign line = lane_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss -> four beat requests -> one-cycle fill pulse; >=5 cycles miss-to-fill, waits on mem_ready.
// ICACHE_CWF_EN: critical-word-first beat order plus crit_valid/crit_word early restart; flush aborts at any edge.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 miss_valid,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic                 flush,
    icache_refill_ctrl_if.master mem,
    output logic                 fill_valid,
    output logic [ADDR_W-1:0]    fill_addr,
    output logic [LINE_W-1:0]    fill_line,
    output logic                 stall,
    output logic [CNT_W-1:0]     miss_count
`ifdef ICACHE_CWF_EN
    ,
    output logic                 crit_valid,
    output logic [WORD_W-1:0]    crit_word
`endif
);

    state_t            state_q, state_d;
    beat_t             beat_q, beat_d, done_q, done_d, first_beat;
    logic [ADDR_W-1:0] base_d, mem_addr_d;
    logic [CNT_W-1:0]  miss_count_d;
    logic              lane_we;

`ifdef ICACHE_CWF_EN
    assign first_beat = beat_t'(miss_addr[3:2]);
`else
    assign first_beat = '0;
`endif

    // fill_addr doubles as the latched line base for address generation.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        done_d       = done_q;
        base_d       = fill_addr;
        mem_addr_d   = mem.mem_addr;
        miss_count_d = miss_count;
        lane_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (miss_valid) begin
                state_d    = ST_REQ;
                base_d     = line_base(miss_addr);
                beat_d     = first_beat;
                done_d     = '0;
                mem_addr_d = line_base(miss_addr) | ADDR_W'({first_beat, 2'b00});
                if (miss_count != '1) miss_count_d = miss_count + 1'b1;
            end
            ST_REQ: if (mem.mem_ready) begin
                lane_we = 1'b1;
                if (done_q == beat_t'(BEATS - 1)) begin
                    state_d = ST_FILL;
                end else begin
                    beat_d     = beat_q + 1'b1;
                    done_d     = done_q + 1'b1;
                    mem_addr_d = fill_addr | ADDR_W'({beat_q + 1'b1, 2'b00});
                end
            end
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            beat_d       = '0;
            done_d       = '0;
            base_d       = fill_addr;
            mem_addr_d   = mem.mem_addr;
            miss_count_d = miss_count;
            lane_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            done_q       <= '0;
            fill_addr    <= '0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            fill_valid   <= 1'b0;
            stall        <= 1'b0;
            miss_count   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            done_q       <= done_d;
            fill_addr    <= base_d;
            mem.mem_req  <= (state_d == ST_REQ);
            mem.mem_addr <= mem_addr_d;
            fill_valid   <= (state_d == ST_FILL);
            stall        <= (state_d != ST_IDLE);
            miss_count   <= miss_count_d;
        end
    end

`ifdef ICACHE_CWF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            crit_valid <= lane_we && (done_q == '0);
            if (lane_we && (done_q == '0)) crit_word <= mem.mem_rdata;
        end
    end
`endif

    refill_line_buf u_line_buf (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (flush),
        .we    (lane_we),
        .idx   (beat_q),
        .wdata (mem.mem_rdata),
        .line  (fill_line)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed and random refills against a line/beat-order model;
// a second instance with a 3-bit counter shares all stimulus to exercise counter saturation.
module tb_icache_refill_ctrl;
    import icache_pkg::*;

    logic              clk = 1'b0;
    logic              rstn, miss_valid, flush;
    logic [ADDR_W-1:0] miss_addr;
    logic              fill_valid, stall, fill_valid2, stall2;
    logic [ADDR_W-1:0] fill_addr, fill_addr2;
    logic [LINE_W-1:0] fill_line, fill_line2;
    logic [15:0]       miss_count;
    logic [2:0]        miss_count2;
`ifdef ICACHE_CWF_EN
    logic              crit_valid, crit_valid2;
    logic [WORD_W-1:0] crit_word, crit_word2;
`endif

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [31:0] salt = 32'h0;

    icache_refill_ctrl_if mem_if();
    icache_refill_ctrl_if mem_if2();
    assign mem_if2.mem_ready = mem_if.mem_ready;
    assign mem_if2.mem_rdata = mem_if.mem_rdata;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .rstn(rstn), .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .mem(mem_if), .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
        .stall(stall), .miss_count(miss_count)
`ifdef ICACHE_CWF_EN
        , .crit_valid(crit_valid), .crit_word(crit_word)
`endif
    );

    icache_refill_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rstn(rstn), .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .mem(mem_if2), .fill_valid(fill_valid2), .fill_addr(fill_addr2), .fill_line(fill_line2),
        .stall(stall2), .miss_count(miss_count2)
`ifdef ICACHE_CWF_EN
        , .crit_valid(crit_valid2), .crit_word(crit_word2)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts();
        chk("miss_count", miss_count, exp_cnt);
        chk("miss_count_sat", miss_count2, (exp_cnt > 7) ? 7 : exp_cnt);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", {mem_if.mem_req, mem_if2.mem_req}, 0);
        chk("rst_addr", mem_if.mem_addr, 0);
        chk("rst_fill_valid", {fill_valid, fill_valid2}, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_line", fill_line, 0);
        chk("rst_stall", {stall, stall2}, 0);
        chk("rst_count", {miss_count, miss_count2}, 0);
`ifdef ICACHE_CWF_EN
        chk("rst_crit", {crit_valid, crit_valid2, crit_word}, 0);
`endif
    endtask

    // One miss at addr; every beat waits wmin..wmax cycles; flush together with ready on beat
    // flush_beat (-1 = never); hold keeps miss_valid asserted through the refill.
    task automatic run_miss(input logic [31:0] addr, input int wmin, input int wmax,
                            input int flush_beat, input bit hold);
        logic [31:0]  base, a;
        logic [127:0] line;
        int           first, idx, w;
        base = addr & 32'hFFFF_FFF0;
`ifdef ICACHE_CWF_EN
        first = int'(addr[3:2]);
`else
        first = 0;
`endif
        salt = $urandom;
        for (int k = 0; k < 4; k++) line[32*k +: 32] = mem_word(base + 32'(4*k));

        chk("idle_stall", {stall, stall2}, 0);
        chk("idle_req", mem_if.mem_req, 0);
        miss_valid = 1'b1;
        miss_addr  = addr;
        @(negedge clk);
        miss_valid = hold;
        miss_addr  = $urandom;
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            idx = (first + i) % 4;
            a   = base + 32'(4*idx);
            w   = $urandom_range(wmax, wmin);
            for (int j = 0; j <= w; j++) begin
                chk("req", {mem_if.mem_req, mem_if2.mem_req}, 2'b11);
                chk("req_addr", {mem_if.mem_addr, mem_if2.mem_addr}, {a, a});
                chk("req_stall", {stall, stall2}, 2'b11);
                chk("req_no_fill", fill_valid, 0);
                if (j < w) @(negedge clk);
            end
            mem_if.mem_ready = 1'b1;
            mem_if.mem_rdata = mem_word(a);
            if (i == flush_beat) flush = 1'b1;
            @(negedge clk);
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = $urandom;
`ifdef ICACHE_CWF_EN
            chk("crit_valid", {crit_valid, crit_valid2}, {2{(i == 0) && (flush_beat != 0)}});
            if (i == 0 && flush_beat != 0)
                chk("crit_word", {crit_word, crit_word2}, {2{line[32*idx +: 32]}});
`endif
            if (i == flush_beat) begin
                flush      = 1'b0;
                miss_valid = 1'b0;
                chk("flush_req", mem_if.mem_req, 0);
                chk("flush_stall", {stall, stall2}, 0);
                chk("flush_no_fill", fill_valid, 0);
                chk("flush_line_clr", fill_line, 0);
                @(negedge clk);
                chk("flush_no_fill_late", {fill_valid, stall}, 0);
                chk_counts();
                return;
            end
        end
        chk("fill_valid", fill_valid, 1);
        chk("fill_addr", fill_addr, base);
        chk("fill_line", fill_line, line);
        chk("fill_sat", {fill_valid2, fill_addr2, fill_line2}, {1'b1, base, line});
        chk("fill_stall", {stall, stall2}, 2'b11);
        chk("fill_no_req", mem_if.mem_req, 0);
        @(negedge clk);
        miss_valid = 1'b0;
        chk("fill_one_cycle", fill_valid, 0);
        chk("post_fill_stall", {stall, stall2}, 0);
        chk_counts();
    endtask

    initial begin
        rstn             = 1'b0;
        miss_valid       = 1'b0;
        miss_addr        = '0;
        flush            = 1'b0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();
        rstn = 1'b1;
        @(negedge clk);

        run_miss(32'h0000_1234, 0, 0, -1, 1'b0);
        run_miss(32'h0000_1234, 3, 3, -1, 1'b0);
        run_miss(32'h0000_1234, 0, 1, 2, 1'b0);
        run_miss(32'h0000_0040, 0, 0, -1, 1'b0);
        run_miss(32'h8000_0010, 0, 2, -1, 1'b1);
        run_miss(32'h0000_1238, 0, 0, -1, 1'b0);
        run_miss(32'hFFFF_FFFC, 1, 2, 0, 1'b0);

        // miss coinciding with flush in IDLE is not accepted
        miss_valid = 1'b1;
        flush      = 1'b1;
        miss_addr  = 32'h0000_5000;
        @(negedge clk);
        miss_valid = 1'b0;
        flush      = 1'b0;
        chk("idle_flush_stall", {stall, mem_if.mem_req}, 0);
        chk_counts();

        // asynchronous reset while waiting on a beat
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_2004;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_if.mem_req, 1);
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        exp_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_miss(32'h0000_0040, 0, 0, -1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_miss($urandom, 0, 3,
                     ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                     1'($urandom_range(1, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
